// File: rtl/hue_pwm_engine.sv
`default_nettype none
// ============================================================================
// Module   : hue_pwm_engine
// Purpose  : Drives NUM_LEDS RGB LEDs with PWM. Each LED shows a fully
//            saturated colour. The LEDs are spaced evenly around the hue
//            circle, starting from a base hue. The base hue can rotate
//            (CYCLE), stay fixed (HOLD), stay fixed with a triangular
//            brightness envelope (BREATHE), or the outputs can be blanked
//            (OFF). Hue and brightness are loaded through a valid/ready
//            handshake that is accepted once per PWM period.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            mode[1:0]           - 0 CYCLE, 1 HOLD, 2 BREATHE, 3 OFF
//            cfg_valid/cfg_ready - config handshake (ready at end of period)
//            cfg_hue[8:0]        - hue to load in degrees (clamped to 359)
//            cfg_bright          - brightness to load
//            hue[8:0]            - current base hue
//            step_pulse          - one-cycle strobe after each step tick
//            rgb_r/g/b           - PWM outputs, bit i drives LED i
// Revision : 1.0 - initial release
// ============================================================================
module hue_pwm_engine #(
    parameter int CLK_FREQUENCY = 12000000,
    parameter int STEPS_PER_SEC = 360,
    parameter int PWM_BITS      = 8,
    parameter int NUM_LEDS      = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic                cfg_valid,
    input  logic [8:0]          cfg_hue,
    input  logic [PWM_BITS-1:0] cfg_bright,
    output logic                cfg_ready,
    output logic [8:0]          hue,
    output logic                step_pulse,
    output logic [NUM_LEDS-1:0] rgb_r,
    output logic [NUM_LEDS-1:0] rgb_g,
    output logic [NUM_LEDS-1:0] rgb_b
);

    localparam int c_STEP_INTERVAL = CLK_FREQUENCY / STEPS_PER_SEC;
    localparam int c_PRESC_W       = (c_STEP_INTERVAL > 1) ? $clog2(c_STEP_INTERVAL) : 1;
    localparam int c_HUE_SPACING   = 360 / NUM_LEDS;
    localparam int c_DW            = NUM_LEDS * PWM_BITS;

    localparam logic [PWM_BITS-1:0]  c_MAX       = '1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_TOP = c_PRESC_W'(c_STEP_INTERVAL - 1);

    localparam logic [1:0] c_MODE_CYCLE   = 2'd0;
    localparam logic [1:0] c_MODE_BREATHE = 2'd2;
    localparam logic [1:0] c_MODE_OFF     = 2'd3;

    // ------------------------------------------------------------------
    // Colour helpers
    // ------------------------------------------------------------------
    // Hue (0..359) to fully saturated {R,G,B} at full scale.
    function automatic logic [3*PWM_BITS-1:0] raw_colour(input logic [9:0] h);
        logic [2:0]            seg;
        logic [9:0]            base;
        logic [9:0]            f;
        logic [PWM_BITS+9:0]   prod;
        logic [PWM_BITS-1:0]   up;
        logic [PWM_BITS-1:0]   dn;
        logic [3*PWM_BITS-1:0] rgb;
        seg  = 3'd0;
        base = 10'd0;
        // The 60-degree segment is found with compares, not a divider.
        for (int s = 1; s < 6; s++) begin
            if (h >= 10'(60 * s)) begin
                seg  = 3'(s);
                base = 10'(60 * s);
            end
        end
        f    = h - base;
        prod = (PWM_BITS+10)'(f) * (PWM_BITS+10)'(c_MAX);
        up   = PWM_BITS'(prod / (PWM_BITS+10)'(60));
        dn   = c_MAX - up;
        case (seg)
            3'd0:    rgb = {c_MAX, up, {PWM_BITS{1'b0}}};
            3'd1:    rgb = {dn, c_MAX, {PWM_BITS{1'b0}}};
            3'd2:    rgb = {{PWM_BITS{1'b0}}, c_MAX, up};
            3'd3:    rgb = {{PWM_BITS{1'b0}}, dn, c_MAX};
            3'd4:    rgb = {up, {PWM_BITS{1'b0}}, c_MAX};
            3'd5:    rgb = {c_MAX, {PWM_BITS{1'b0}}, dn};
            default: rgb = '0;
        endcase
        return rgb;
    endfunction

    // (a * (b + 1)) >> PWM_BITS with a product wide enough never to overflow.
    function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] a,
                                                  input logic [PWM_BITS-1:0] b);
        logic [2*PWM_BITS:0] p;
        p = (2*PWM_BITS+1)'(a) * ((2*PWM_BITS+1)'(b) + (2*PWM_BITS+1)'(1));
        return PWM_BITS'(p >> PWM_BITS);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_PRESC_W-1:0] presc_q,      presc_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q,    pwm_cnt_d;
    logic                 step_pulse_q, step_pulse_d;
    logic [8:0]           hue_q,        hue_d;
    logic [PWM_BITS-1:0]  bright_q,     bright_d;
    logic [PWM_BITS-1:0]  env_q,        env_d;
    logic                 env_up_q,     env_up_d;
    logic [c_DW-1:0]      duty_r_q,     duty_r_d;
    logic [c_DW-1:0]      duty_g_q,     duty_g_d;
    logic [c_DW-1:0]      duty_b_q,     duty_b_d;
    logic [NUM_LEDS-1:0]  rgb_r_q,      rgb_r_d;
    logic [NUM_LEDS-1:0]  rgb_g_q,      rgb_g_d;
    logic [NUM_LEDS-1:0]  rgb_b_q,      rgb_b_d;

    logic                 w_tick;
    logic                 w_load;
    logic                 w_xfer;
    logic [PWM_BITS-1:0]  w_level;
    logic [c_DW-1:0]      w_duty_r, w_duty_g, w_duty_b;
    logic [NUM_LEDS-1:0]  w_on_r,   w_on_g,   w_on_b;

    assign w_tick    = (presc_q == c_PRESC_TOP);
    assign w_load    = (pwm_cnt_q == c_MAX);
    assign cfg_ready = w_load && !rst;
    assign w_xfer    = cfg_valid && cfg_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        presc_d      = w_tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d    = pwm_cnt_q + 1'b1;
        step_pulse_d = w_tick;

        // A transfer wins over a same-cycle hue step.
        hue_d    = hue_q;
        bright_d = bright_q;
        if (w_xfer) begin
            hue_d    = (cfg_hue > 9'd359) ? 9'd359 : cfg_hue;
            bright_d = cfg_bright;
        end else if (w_tick && (mode == c_MODE_CYCLE)) begin
            hue_d = (hue_q == 9'd359) ? 9'd0 : hue_q + 9'd1;
        end

        // Triangular envelope: direction flips on the step that lands on an
        // endpoint, so the endpoint value lasts exactly one step.
        env_d    = env_q;
        env_up_d = env_up_q;
        if (w_tick && (mode == c_MODE_BREATHE)) begin
            if (env_up_q) begin
                env_d = env_q + 1'b1;
                if (env_q == c_MAX - 1'b1) begin
                    env_up_d = 1'b0;
                end
            end else begin
                env_d = env_q - 1'b1;
                if (env_q == {{(PWM_BITS-1){1'b0}}, 1'b1}) begin
                    env_up_d = 1'b1;
                end
            end
        end

        // Duties change only at the period boundary, using post-transfer values.
        duty_r_d = w_load ? w_duty_r : duty_r_q;
        duty_g_d = w_load ? w_duty_g : duty_g_q;
        duty_b_d = w_load ? w_duty_b : duty_b_q;

        rgb_r_d = (mode == c_MODE_OFF) ? '0 : w_on_r;
        rgb_g_d = (mode == c_MODE_OFF) ? '0 : w_on_g;
        rgb_b_d = (mode == c_MODE_OFF) ? '0 : w_on_b;
    end

    assign w_level = (mode == c_MODE_BREATHE) ? scale(bright_d, env_d) : bright_d;

    // ------------------------------------------------------------------
    // Per-LED colour, scaled duty and PWM compare
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        localparam logic [9:0] c_OFFSET = 10'(i * c_HUE_SPACING);

        logic [9:0]            w_h_sum;
        logic [9:0]            w_h;
        logic [3*PWM_BITS-1:0] w_raw;

        // Base hue <= 359 and offset < 360, so one subtraction is a full mod.
        assign w_h_sum = {1'b0, hue_d} + c_OFFSET;
        assign w_h     = (w_h_sum >= 10'd360) ? w_h_sum - 10'd360 : w_h_sum;
        assign w_raw   = raw_colour(w_h);

        assign w_duty_r[i*PWM_BITS +: PWM_BITS] = scale(w_raw[3*PWM_BITS-1 -: PWM_BITS], w_level);
        assign w_duty_g[i*PWM_BITS +: PWM_BITS] = scale(w_raw[2*PWM_BITS-1 -: PWM_BITS], w_level);
        assign w_duty_b[i*PWM_BITS +: PWM_BITS] = scale(w_raw[PWM_BITS-1   -: PWM_BITS], w_level);

        assign w_on_r[i] = (pwm_cnt_q < duty_r_q[i*PWM_BITS +: PWM_BITS]);
        assign w_on_g[i] = (pwm_cnt_q < duty_g_q[i*PWM_BITS +: PWM_BITS]);
        assign w_on_b[i] = (pwm_cnt_q < duty_b_q[i*PWM_BITS +: PWM_BITS]);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            pwm_cnt_q    <= '0;
            step_pulse_q <= 1'b0;
            hue_q        <= 9'd0;
            bright_q     <= c_MAX;
            env_q        <= '0;
            env_up_q     <= 1'b1;
            duty_r_q     <= '0;
            duty_g_q     <= '0;
            duty_b_q     <= '0;
            rgb_r_q      <= '0;
            rgb_g_q      <= '0;
            rgb_b_q      <= '0;
        end else begin
            presc_q      <= presc_d;
            pwm_cnt_q    <= pwm_cnt_d;
            step_pulse_q <= step_pulse_d;
            hue_q        <= hue_d;
            bright_q     <= bright_d;
            env_q        <= env_d;
            env_up_q     <= env_up_d;
            duty_r_q     <= duty_r_d;
            duty_g_q     <= duty_g_d;
            duty_b_q     <= duty_b_d;
            rgb_r_q      <= rgb_r_d;
            rgb_g_q      <= rgb_g_d;
            rgb_b_q      <= rgb_b_d;
        end
    end

    assign hue        = hue_q;
    assign step_pulse = step_pulse_q;
    assign rgb_r      = rgb_r_q;
    assign rgb_g      = rgb_g_q;
    assign rgb_b      = rgb_b_q;

endmodule
`default_nettype wire
